// File: rtl/mips_fetch_unit.sv
// Instruction fetch/prefetch stage: one outstanding imem read, a small PC-tagged FIFO,
// and a valid/ready hand-off to decode. A redirect flushes buffered and in-flight work.
module mips_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFlush
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     w_fetch_pc_next;
  logic [31:0]     w_redirect_pc;
  logic [31:0]     r_inst_mem [DEPTH];
  logic [31:0]     r_pc_mem   [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_inc;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign inst_valid    = (r_count != '0);
  assign inst          = r_inst_mem[r_rd_ptr];
  assign inst_pc       = r_pc_mem[r_rd_ptr];
  assign imem_addr     = r_fetch_pc;
  assign imem_req      = (r_state == StBusy) || (r_state == StFlush);
  // Redirect wins over the consumer: the head is discarded, not handed over.
  assign w_pop         = inst_valid & inst_ready & ~redirect;
  // Occupancy after a push this cycle, accounting for a simultaneous pop.
  assign w_count_inc   = w_pop ? r_count : r_count + CntW'(1);

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_push          = 1'b0;
    w_flush         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (redirect) begin
          w_fetch_pc_next = w_redirect_pc;
          w_flush         = 1'b1;
          w_state_next    = StBusy;
        end else if (r_count < FullCnt) begin
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        if (redirect) begin
          w_fetch_pc_next = w_redirect_pc;
          w_flush         = 1'b1;
          // Without an ack the old response is still coming and must be dropped.
          if (!imem_ack) begin
            w_state_next = StFlush;
          end
        end else if (imem_ack) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
          if (w_count_inc == FullCnt) begin
            w_state_next = StIdle;
          end
        end
      end
      StFlush: begin
        if (redirect) begin
          w_fetch_pc_next = w_redirect_pc;
          w_flush         = 1'b1;
        end
        if (imem_ack) begin
          w_state_next = StBusy;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push) begin
        r_count <= w_count_inc;
      end else if (w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else if (w_push) begin
      r_inst_mem[r_wr_ptr] <= imem_rdata;
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: directed scenarios push expected {pc, inst} pairs,
// a negedge monitor pops and compares on every accepted instruction.
module tb_mips_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int          n_checks;
  int          n_errors;
  int          lat;
  int          mem_cnt;
  logic [63:0] sb_q[$];

  mips_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after lat idle cycles, returns the word equal to its address.
  assign imem_ack   = imem_req && (mem_cnt == lat);
  assign imem_rdata = imem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt <= 0;
    end else if (!imem_req || imem_ack) begin
      mem_cnt <= 0;
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redirect) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, expected no output", inst_pc, inst);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        if ({inst_pc, inst} !== e) begin
          n_errors++;
          $display("FAIL sb_entry: got pc=%h inst=%h, expected pc=%h inst=%h",
                   inst_pc, inst, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] pc);
    sb_q.push_back({pc, pc});
  endtask

  task automatic exp_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_push(start + 32'(4 * i));
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    inst_ready = 1'b0;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: %0d entries outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Leaves the bench one time step after the edge that follows reset release.
  task automatic do_reset(input int latency);
    rst        = 1'b1;
    inst_ready = 1'b0;
    redirect   = 1'b0;
    redirect_pc = '0;
    lat        = latency;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    lat         = 0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;

    // Reset state, 2-cycle first-fetch latency, streaming at one per cycle.
    tick(1);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    do_reset(0);
    inst_ready = 1'b1;
    exp_seq(32'h0, 6);
    tick(1);
    chk("s1_valid_e1", 32'(inst_valid), 32'd0);
    chk("s1_req_e1", 32'(imem_req), 32'd1);
    chk("s1_addr_e1", imem_addr, 32'h0);
    tick(1);
    chk("s1_valid_e2", 32'(inst_valid), 32'd1);
    chk("s1_addr_e2", imem_addr, 32'h4);
    tick(1);
    chk("s1_addr_e3", imem_addr, 32'h8);
    chk("s1_pc_e3", inst_pc, 32'h4);
    wait_drain(40);

    // Backpressure: four pushes fill the FIFO, request stops, then resumes at 16.
    do_reset(0);
    tick(5);
    chk("s2_req_full", 32'(imem_req), 32'd0);
    tick(2);
    chk("s2_req_idle", 32'(imem_req), 32'd0);
    chk("s2_valid_full", 32'(inst_valid), 32'd1);
    chk("s2_head_pc", inst_pc, 32'h0);
    exp_seq(32'h0, 7);
    inst_ready = 1'b1;
    tick(2);
    chk("s2_req_resume", 32'(imem_req), 32'd1);
    chk("s2_addr_resume", imem_addr, 32'h10);
    wait_drain(40);

    // Slow memory, redirect while the request to 0x8 is pending.
    do_reset(3);
    tick(10);
    chk("s3_addr_pre", imem_addr, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick(1);
    redirect = 1'b0;
    chk("s3_addr_redir", imem_addr, 32'h100);
    chk("s3_req_flush", 32'(imem_req), 32'd1);
    chk("s3_valid_cleared", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    exp_push(32'h100);
    exp_push(32'h104);
    tick(2);
    chk("s3_stale_dropped", 32'(inst_valid), 32'd0);
    chk("s3_addr_reissue", imem_addr, 32'h100);
    tick(4);
    chk("s3_first_valid", 32'(inst_valid), 32'd1);
    chk("s3_first_pc", inst_pc, 32'h100);
    wait_drain(40);

    // Redirect coinciding with the ack for 0x10; low target bits are ignored.
    do_reset(0);
    inst_ready = 1'b1;
    exp_seq(32'h0, 3);
    exp_seq(32'h200, 2);
    tick(5);
    chk("s4_addr_pre", imem_addr, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    tick(1);
    redirect = 1'b0;
    chk("s4_valid_after", 32'(inst_valid), 32'd0);
    chk("s4_addr_aligned", imem_addr, 32'h200);
    tick(1);
    chk("s4_pc_target", inst_pc, 32'h200);
    wait_drain(40);

    // Redirect beats a simultaneous pop with two entries buffered.
    do_reset(0);
    tick(3);
    chk("s5_valid_two", 32'(inst_valid), 32'd1);
    chk("s5_head_pc", inst_pc, 32'h0);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    exp_push(32'h300);
    exp_push(32'h304);
    tick(1);
    redirect = 1'b0;
    chk("s5_valid_after", 32'(inst_valid), 32'd0);
    chk("s5_addr_target", imem_addr, 32'h300);
    wait_drain(40);

    // Asynchronous reset in the middle of a request to 0x40.
    do_reset(0);
    inst_ready = 1'b1;
    exp_seq(32'h0, 15);
    tick(17);
    chk("s6_addr_pre", imem_addr, 32'h40);
    chk("s6_req_pre", 32'(imem_req), 32'd1);
    chk("s6_sb_drained", 32'(sb_q.size()), 32'd0);
    rst = 1'b1;
    #1;
    chk("s6_req_async", 32'(imem_req), 32'd0);
    chk("s6_valid_async", 32'(inst_valid), 32'd0);
    chk("s6_addr_async", imem_addr, 32'h0);
    tick(1);
    rst = 1'b0;
    exp_seq(32'h0, 2);
    tick(1);
    chk("s6_addr_restart", imem_addr, 32'h0);
    chk("s6_req_restart", 32'(imem_req), 32'd1);
    wait_drain(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction fetch and prefetch stage that sits directly upstream of the single-cycle MIPS datapath/controller pair.
- Issues word reads to an instruction memory over a req/ack handshake and buffers the returned words in a small FIFO.
- Hands instructions, each tagged with its PC, to the decode/execute side over a valid/ready handshake.
- Accepts a redirect (taken branch or jump, driven from the PCSrc path) that flushes all buffered and in-flight work.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned read address; bits [1:0] are always 0.
- imem_ack  in  1  memory has returned data for the current request.
- imem_rdata  in  32  instruction word; sampled only when imem_ack=1.
- redirect  in  1  flush the stage and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst  out  32  instruction word at the FIFO head.
- inst_pc  out  32  PC of the instruction at the FIFO head.
- inst_ready  in  1  consumer accepts the head entry this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, count=0, fetch_pc=RESET_PC.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0.
- Outputs:
  - imem_addr=fetch_pc at all times.
  - imem_req=1 exactly in states BUSY and FLUSH.
  - imem_addr must stay stable while imem_req=1 and imem_ack=0.
- At most one memory request is outstanding. count is the number of FIFO entries, range 0..DEPTH.
- pop = inst_valid & inst_ready & ~redirect. inst_valid = (count != 0). inst and inst_pc reflect the head entry combinationally.
- State IDLE (no request outstanding):
  - If redirect: fetch_pc<=redirect_pc, FIFO cleared, next state BUSY.
  - Else if count<DEPTH: next state BUSY.
  - Else stay IDLE.
- State BUSY (request outstanding for fetch_pc):
  - redirect & imem_ack: the returned word is dropped; FIFO cleared; fetch_pc<=redirect_pc; stay BUSY.
  - redirect & ~imem_ack: FIFO cleared; fetch_pc<=redirect_pc; next state FLUSH. imem_addr changes to the new value, which memory must tolerate as the request being reissued.
  - imem_ack & ~redirect: push {fetch_pc, imem_rdata}; fetch_pc<=fetch_pc+4, wrapping mod 2^32. count_next=count+1-pop. Stay BUSY if count_next<DEPTH, else go to IDLE.
  - Neither: hold.
- State FLUSH (the response to an abandoned request is still pending):
  - imem_ack: discard the data and go to BUSY; fetch_pc is unchanged, since it already holds the redirect target.
  - redirect: fetch_pc<=redirect_pc.
  - Both in the same cycle: the data is discarded, fetch_pc<=redirect_pc, next state BUSY.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - Pushing into a full FIFO is impossible by construction, because a request is issued only when count<DEPTH and at most one is outstanding.
- redirect has priority over pop: the head entry is not consumed and all entries are discarded. inst_valid=0 in the cycle after a redirect.
- With zero-wait memory (imem_ack tied high) and inst_ready=1, throughput is one instruction per cycle.
- Latency from reset release to the first inst_valid is 2 cycles: IDLE->BUSY, then ack and push.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.

Test Plan:
- Reset, zero-wait memory returning the word equal to its address, inst_ready=1 -> imem_addr sequence 0,4,8,...; inst_pc=0,4,8 on consecutive cycles with inst=inst_pc.
- inst_ready=0 with DEPTH=4 -> exactly 4 pushes (PCs 0,4,8,12), then imem_req=0 and state IDLE. Raise inst_ready -> 4 pops in order, and fetch resumes at 16.
- Memory with 3-cycle ack; redirect to 0x100 one cycle after a request to 0x8 -> the 0x8 response is discarded, the next request goes to 0x100, and the first inst_pc seen is 0x100.
- redirect to 0x203 in the same cycle as imem_ack for PC 0x10 -> the 0x10 word never appears; the next imem_addr=0x200 (low bits forced to 0).
- FIFO holding 2 entries, redirect and inst_ready both high -> no entry is consumed, inst_valid=0 on the next cycle, and count=0.
- Assert rst mid-request, with imem_req=1 at PC 0x40 -> imem_req drops immediately (asynchronously) and inst_valid=0. After release, fetch restarts at RESET_PC=0.
